// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// Holds default bus widths, the ALU control encodings understood by the external ALU,
// and the encoding of the arbiter's result-register state.
package alu_pkg;

  localparam int unsigned ALU_WIDTH  = 32;
  localparam int unsigned ALU_CTRL_W = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_NOP = 3'b111;

  // FREE: result register empty. HOLD: result register valid, owned by one requester.
  typedef enum logic {
    ST_FREE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between two ALU requesters, the sharing arbiter and the external ALU.
//   req0_* / req1_* : request channels (valid/ready, operands, control)
//   rsp0_* / rsp1_* : response handshakes; rsp_result/rsp_zero is the shared response bus
//   alu_*           : operand/control bus to the ALU and its combinational result
// Modports: slave = arbiter side, master = requester/ALU environment side.
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 3
);

  logic              req0_valid;
  logic              req0_ready;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;
  logic [CTRL_W-1:0] req0_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;
  logic [CTRL_W-1:0] req1_ctrl;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_zero;

  logic [WIDTH-1:0]  alu_srcA;
  logic [WIDTH-1:0]  alu_srcB;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    output req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    input  rsp0_ready, rsp1_ready,
    output alu_srcA, alu_srcB, alu_ctrl,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    output rsp0_ready, rsp1_ready,
    input  alu_srcA, alu_srcB, alu_ctrl,
    output alu_result, alu_zero
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input round-robin grant.
//   clk, rst_n : clock, synchronous active-low reset
//   req[1:0]   : qualified requests (already gated by the caller's issue condition)
//   advance    : a grant is taken this cycle; rotate priority away from the winner
//   gnt[1:0]   : one-hot grant, all-zero when no request
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio_q == 1 means requester 1 wins a tie.
  logic prio_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (advance) begin
      // Winner 0 hands priority to 1 and vice versa.
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request channels, response handshakes/shared result bus, ALU operand bus
// One operation is issued per grant cycle; its result is registered and held until the
// owning requester takes it. Draining and issuing in the same cycle gives full throughput.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned       WIDTH     = ALU_WIDTH,
  parameter int unsigned       CTRL_W    = ALU_CTRL_W,
  parameter logic [CTRL_W-1:0] IDLE_CTRL = {CTRL_W{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus
);

  state_e           state_q;
  logic             owner_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic       owner_ready;
  logic       can_issue;
  logic       issue;
  logic [1:0] arb_req;
  logic [1:0] gnt;

  // Only the owner's rsp_ready can free the result register.
  assign owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  // rst_n in the term keeps both req_ready low while reset is asserted.
  assign can_issue   = rst_n && ((state_q == ST_FREE) || owner_ready);
  assign arb_req     = {bus.req1_valid, bus.req0_valid} & {2{can_issue}};
  assign issue       = |arb_req;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (issue),
    .gnt     (gnt)
  );

  always_comb begin
    bus.req0_ready = gnt[0];
    bus.req1_ready = gnt[1];
    bus.alu_srcA   = '0;
    bus.alu_srcB   = '0;
    bus.alu_ctrl   = IDLE_CTRL;
    unique case (gnt)
      2'b01: begin
        bus.alu_srcA = bus.req0_a;
        bus.alu_srcB = bus.req0_b;
        bus.alu_ctrl = bus.req0_ctrl;
      end
      2'b10: begin
        bus.alu_srcA = bus.req1_a;
        bus.alu_srcB = bus.req1_b;
        bus.alu_ctrl = bus.req1_ctrl;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FREE;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (issue) begin
      // Covers both a fresh issue and drain-plus-issue in the same cycle.
      state_q  <= ST_HOLD;
      owner_q  <= gnt[1];
      result_q <= bus.alu_result;
      zero_q   <= bus.alu_zero;
    end else if ((state_q == ST_HOLD) && owner_ready) begin
      // Result bus keeps its last value; it is don't-care once no rsp valid is high.
      state_q <= ST_FREE;
    end
  end

  assign bus.rsp0_valid = (state_q == ST_HOLD) && !owner_q;
  assign bus.rsp1_valid = (state_q == ST_HOLD) && owner_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against hand-computed values and a
// small reference model. The bench also plays the external ALU.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(32), .CTRL_W(3)) bus ();

  alu_share_arbiter #(
    .WIDTH     (32),
    .CTRL_W    (3),
    .IDLE_CTRL (3'b111)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {31'b0, ($signed(a) < $signed(b))};
      default: return 32'h0;
    endcase
  endfunction

  // External combinational ALU.
  always_comb begin
    bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_srcA, bus.alu_srcB);
    bus.alu_zero   = (alu_fn(bus.alu_ctrl, bus.alu_srcA, bus.alu_srcB) == 32'h0);
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_rsp0_valid got %b want 0", bus.rsp0_valid); end
    n_cmp++; if (bus.rsp1_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_rsp1_valid got %b want 0", bus.rsp1_valid); end
    n_cmp++; if (bus.rsp_result !== 32'h0) begin n_bad++;
      $display("FAIL reset_rsp_result got %h want 0", bus.rsp_result); end
    n_cmp++; if (bus.rsp_zero !== 1'b0) begin n_bad++;
      $display("FAIL reset_rsp_zero got %b want 0", bus.rsp_zero); end
    n_cmp++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_bad++;
      $display("FAIL reset_req_ready got %b%b want 00", bus.req1_ready, bus.req0_ready); end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_ctrl = ALU_ADD;
    bus.rsp0_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_bad++;
      $display("FAIL single_ready got %b%b want 01", bus.req1_ready, bus.req0_ready); end
    n_cmp++; if (bus.alu_srcA !== 32'd5 || bus.alu_srcB !== 32'd7 || bus.alu_ctrl !== 3'b000)
      begin n_bad++; $display("FAIL single_alu_bus got %h %h %b want 5 7 000",
        bus.alu_srcA, bus.alu_srcB, bus.alu_ctrl); end
    @(negedge clk);
    n_cmp++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin n_bad++;
      $display("FAIL single_rsp_valid got %b%b want 01", bus.rsp1_valid, bus.rsp0_valid); end
    n_cmp++; if (bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0) begin n_bad++;
      $display("FAIL single_result got %h/%b want c/0", bus.rsp_result, bus.rsp_zero); end
    bus.req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_bad++;
      $display("FAIL single_drain got rsp0_valid %b want 0", bus.rsp0_valid); end
    bus.rsp0_ready = 1'b0;
  endtask

  // A single op left priority with requester 1; the reset must return it to requester 0.
  task automatic test_round_robin();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_ctrl = ALU_SUB;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFD; bus.req1_b = 32'd2;
    bus.req1_ctrl = ALU_SLT;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      automatic logic g = logic'(i % 2);
      #1;
      n_cmp++; if (bus.req0_ready !== !g || bus.req1_ready !== g) begin n_bad++;
        $display("FAIL rr_grant[%0d] got %b%b want %b%b", i, bus.req1_ready, bus.req0_ready,
                 g, !g); end
      @(negedge clk);
      n_cmp++; if (bus.rsp0_valid !== !g || bus.rsp1_valid !== g) begin n_bad++;
        $display("FAIL rr_rsp_valid[%0d] got %b%b want %b%b", i, bus.rsp1_valid,
                 bus.rsp0_valid, g, !g); end
      n_cmp++; if (bus.rsp_result !== (g ? 32'd1 : 32'd0) || bus.rsp_zero !== !g) begin
        n_bad++; $display("FAIL rr_result[%0d] got %h/%b want %h/%b", i, bus.rsp_result,
                 bus.rsp_zero, (g ? 32'd1 : 32'd0), !g); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin n_bad++;
      $display("FAIL rr_drain got %b%b want 00", bus.rsp1_valid, bus.rsp0_valid); end
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.req1_valid = 1'b1; bus.req1_a = 32'hF0; bus.req1_b = 32'hFF; bus.req1_ctrl = ALU_XOR;
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin n_bad++;
      $display("FAIL bp_grant got %b%b want 10", bus.req1_ready, bus.req0_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_ctrl = ALU_ADD;
      bus.rsp0_ready = 1'b1;  // non-owner ready must be ignored
      #1;
      n_cmp++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 ||
                   bus.rsp_result !== 32'h0F) begin n_bad++;
        $display("FAIL bp_hold[%0d] got v=%b%b res=%h want v=10 res=0f", i, bus.rsp1_valid,
                 bus.rsp0_valid, bus.rsp_result); end
      n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++;
        $display("FAIL bp_stall[%0d] got req0_ready %b want 0", i, bus.req0_ready); end
    end
    @(negedge clk);
    bus.rsp1_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1 || bus.rsp_result !== 32'h0F) begin n_bad++;
      $display("FAIL bp_drain_grant got ready %b res %h want 1 0f", bus.req0_ready,
               bus.rsp_result); end
    @(negedge clk);
    bus.rsp1_ready = 1'b0; bus.req0_valid = 1'b0;
    n_cmp++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 ||
                 bus.rsp_result !== 32'd3 || bus.rsp_zero !== 1'b0) begin n_bad++;
      $display("FAIL bp_next got v=%b%b res=%h z=%b want v=01 res=3 z=0", bus.rsp1_valid,
               bus.rsp0_valid, bus.rsp_result, bus.rsp_zero); end
    @(negedge clk);
    n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_bad++;
      $display("FAIL bp_final_drain got %b want 0", bus.rsp0_valid); end
    bus.rsp0_ready = 1'b0;
  endtask

  task automatic test_undefined_ctrl();
    idle_inputs();
    #1;
    n_cmp++; if (bus.alu_ctrl !== 3'b111 || bus.alu_srcA !== 32'h0 || bus.alu_srcB !== 32'h0)
      begin n_bad++; $display("FAIL idle_bus got %b %h %h want 111 0 0", bus.alu_ctrl,
        bus.alu_srcA, bus.alu_srcB); end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd6; bus.req0_ctrl = 3'b110;
    bus.rsp0_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1 || bus.alu_ctrl !== 3'b110) begin n_bad++;
      $display("FAIL undef_grant got %b ctrl %b want 1 110", bus.req0_ready, bus.alu_ctrl); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_cmp++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 32'h0 || bus.rsp_zero !== 1'b1)
      begin n_bad++; $display("FAIL undef_result got v=%b res=%h z=%b want 1 0 1",
        bus.rsp0_valid, bus.rsp_result, bus.rsp_zero); end
    #1;
    n_cmp++; if (bus.alu_ctrl !== 3'b111 || bus.alu_srcA !== 32'h0) begin n_bad++;
      $display("FAIL idle_bus2 got %b %h want 111 0", bus.alu_ctrl, bus.alu_srcA); end
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    bus.req1_valid = 1'b1; bus.req1_a = 32'd1; bus.req1_b = 32'd1; bus.req1_ctrl = ALU_ADD;
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_bad++;
      $display("FAIL rmh_grant got %b want 1", bus.req1_ready); end
    @(negedge clk);
    n_cmp++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_result !== 32'd2) begin n_bad++;
      $display("FAIL rmh_hold got v=%b res=%h want 1 2", bus.rsp1_valid, bus.rsp_result); end
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd4; bus.req0_b = 32'd6; bus.req0_ctrl = ALU_AND;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_ctrl = ALU_OR;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin n_bad++;
      $display("FAIL rmh_ready_in_reset got %b%b want 00", bus.req1_ready, bus.req0_ready); end
    @(negedge clk);
    n_cmp++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
                 bus.rsp_result !== 32'h0 || bus.rsp_zero !== 1'b0) begin n_bad++;
      $display("FAIL rmh_after_reset got v=%b%b res=%h z=%b want 00 0 0", bus.rsp1_valid,
               bus.rsp0_valid, bus.rsp_result, bus.rsp_zero); end
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_bad++;
      $display("FAIL rmh_tie got %b%b want 01", bus.req1_ready, bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    n_cmp++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 32'd4) begin n_bad++;
      $display("FAIL rmh_rsp0 got v=%b res=%h want 1 4", bus.rsp0_valid, bus.rsp_result); end
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_bad++;
      $display("FAIL rmh_second got %b want 1", bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1'b0;
    n_cmp++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_result !== 32'd3) begin n_bad++;
      $display("FAIL rmh_rsp1 got v=%b res=%h want 1 3", bus.rsp1_valid, bus.rsp_result); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_soak();
    logic        v0 = 1'b0, v1 = 1'b0, r0, r1, ci, g0, g1;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0]  c0 = '0, c1 = '0;
    logic        m_hold = 1'b0, m_owner = 1'b0, m_prio = 1'b0, m_zero = 1'b0;
    logic [31:0] m_res = '0;
    idle_inputs();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      n_cmp++; if (bus.rsp0_valid !== (m_hold && !m_owner) ||
                   bus.rsp1_valid !== (m_hold && m_owner)) begin n_bad++;
        $display("FAIL soak_rsp_valid cyc %0d got %b%b want %b%b", cyc, bus.rsp1_valid,
                 bus.rsp0_valid, m_hold && m_owner, m_hold && !m_owner); end
      if (m_hold) begin
        n_cmp++; if (bus.rsp_result !== m_res || bus.rsp_zero !== m_zero) begin n_bad++;
          $display("FAIL soak_result cyc %0d got %h/%b want %h/%b", cyc, bus.rsp_result,
                   bus.rsp_zero, m_res, m_zero); end
      end
      // Fields stay stable while valid and not yet accepted.
      if (!v0) begin
        v0 = 1'($urandom_range(0, 1)); c0 = 3'($urandom_range(0, 7));
        a0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
        b0 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      end
      if (!v1) begin
        v1 = 1'($urandom_range(0, 1)); c1 = 3'($urandom_range(0, 7));
        a1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
        b1 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
      end
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ctrl = c0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ctrl = c1;
      bus.rsp0_ready = r0; bus.rsp1_ready = r1;
      #1;
      ci = !m_hold || (m_owner ? r1 : r0);
      g0 = ci && v0 && (!v1 || !m_prio);
      g1 = ci && v1 && (!v0 || m_prio);
      n_cmp++; if (bus.req0_ready !== g0 || bus.req1_ready !== g1) begin n_bad++;
        $display("FAIL soak_grant cyc %0d got %b%b want %b%b", cyc, bus.req1_ready,
                 bus.req0_ready, g1, g0); end
      if (g0 || g1) begin
        m_res   = g0 ? alu_fn(c0, a0, b0) : alu_fn(c1, a1, b1);
        m_zero  = (m_res == 32'h0);
        m_hold  = 1'b1;
        m_owner = g1;
        m_prio  = g0;
        if (g0) v0 = 1'b0;
        if (g1) v1 = 1'b0;
      end else if (m_hold && (m_owner ? r1 : r0)) begin
        m_hold = 1'b0;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_undefined_ctrl();
    test_reset_mid_hold();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
